// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame shape and command byte index.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    typedef logic [1:0] byte_idx_t;
    localparam byte_idx_t LAST_BYTE = 2'd2;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: sends resp as start, 8 data bits LSB first, stop.
// Latency: start bit begins the cycle after send_resp is accepted; frame is 10*BAUD_DIV cycles.
// Backpressure: send_resp is ignored while tx_busy is high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4340
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp,
    input  logic       send_resp,
    output logic       TX,
    output logic       tx_busy,
    output logic       resp_sent
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic                   bit_end;

    assign bit_end = (cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            TX        <= 1'b1;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            if (state != ST_IDLE) begin
                cnt <= bit_end ? '0 : cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (send_resp) begin
                        shreg   <= resp;
                        cnt     <= '0;
                        TX      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        TX      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            TX    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            TX      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // busy drops and the completion pulse fires on the same edge
                    if (bit_end) begin
                        tx_busy   <= 1'b0;
                        resp_sent <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_comm_slv.sv
// UART command slave: assembles 3 received bytes into cmd, transmits 1-byte responses.
// Latency: cmd/cmd_rdy update at the third stop-bit midpoint; TX frame starts 1 cycle after send_resp.
// Backpressure: bytes arriving while cmd_rdy is high are dropped with frm_err; send_resp ignored while tx_busy.
module uart_comm_slv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4340
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    uart_state_t            rx_state;
    logic [CNT_W-1:0]       rx_cnt;
    logic [BIT_IDX_W-1:0]   rx_bit_idx;
    logic [DATA_BITS-1:0]   rx_shreg;
    byte_idx_t              byte_idx;
    logic [7:0]             cmd_hi;
    logic [7:0]             cmd_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shreg   <= '0;
            byte_idx   <= '0;
            cmd_hi     <= '0;
            cmd_mid    <= '0;
            cmd        <= '0;
            cmd_rdy    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            // a completing command below overrides this clear
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        rx_state   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit_idx == LAST_BIT) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit_idx <= rx_bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // leave at the stop midpoint so a back-to-back start edge is caught
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                        if (!rx_sync) begin
                            frm_err  <= 1'b1;
                            byte_idx <= '0;
                        end else if (cmd_rdy) begin
                            frm_err <= 1'b1;
                        end else if (byte_idx == LAST_BYTE) begin
                            cmd      <= {cmd_hi, cmd_mid, rx_shreg};
                            cmd_rdy  <= 1'b1;
                            byte_idx <= '0;
                        end else begin
                            if (byte_idx == 2'd0) begin
                                cmd_hi <= rx_shreg;
                            end else begin
                                cmd_mid <= rx_shreg;
                            end
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .resp      (resp),
        .send_resp (send_resp),
        .TX        (TX),
        .tx_busy   (tx_busy),
        .resp_sent (resp_sent)
    );

endmodule

// File: tb/tb_uart_comm_slv.sv
// Scoreboard bench for uart_comm_slv at BAUD_DIV=16 with a byte-level reference model.
module tb_uart_comm_slv;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frm_err;

    always #5 clk = ~clk;

    uart_comm_slv #(.BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .frm_err     (frm_err)
    );

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at edge %0d", name, got, exp, edge_cnt);
        end
    endtask

    task automatic fail_unexp(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=event expected=none at edge %0d", name, edge_cnt);
    endtask

    typedef struct {
        bit          is_cmd;
        logic [23:0] val;
    } rx_ev_t;

    typedef struct {
        logic [7:0] dat;
        int         acc;
    } tx_ev_t;

    rx_ev_t rxq[$];
    tx_ev_t txq[$];

    // Reference model state: bytes collected so far, and whether a command awaits consumption
    logic [7:0] m_buf [3];
    int         m_idx = 0;
    bit         m_rdy = 1'b0;
    int         busy_start = -1000;
    int         prev_start = -1000;

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        rx_ev_t e;
        e.is_cmd = 1'b0;
        e.val    = '0;
        if (!ok) begin
            rxq.push_back(e);
            m_idx = 0;
        end else if (m_rdy) begin
            rxq.push_back(e);
        end else begin
            m_buf[m_idx] = b;
            m_idx++;
            if (m_idx == 3) begin
                e.is_cmd = 1'b1;
                e.val    = {m_buf[0], m_buf[1], m_buf[2]};
                rxq.push_back(e);
                m_idx = 0;
                m_rdy = 1'b1;
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit ok);
        model_byte(b, ok);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = ok;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        if (!ok) repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic clr_pulse();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        chk("clr_next_cycle", cmd_rdy, 0);
    endtask

    // A frame occupies edges [acc, acc+160); the line is free again from acc+161
    task automatic send_tx(input logic [7:0] d);
        tx_ev_t e;
        resp      = d;
        send_resp = 1'b1;
        if (edge_cnt + 1 >= busy_start + 161) begin
            e.dat = d;
            e.acc = edge_cnt + 1;
            txq.push_back(e);
            prev_start = busy_start;
            busy_start = edge_cnt + 1;
        end
        @(negedge clk);
        send_resp = 1'b0;
        resp      = 8'($urandom);
    endtask

    // Receive-side monitor
    initial begin
        bit          rdy_q;
        logic [23:0] cur;
        rx_ev_t      e;
        rdy_q = 1'b0;
        cur   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rdy_q = 1'b0;
                cur   = '0;
            end else begin
                if (frm_err) begin
                    if (rxq.size() == 0) fail_unexp("frm_err_unexpected");
                    else begin
                        e = rxq.pop_front();
                        chk("rx_kind_err", 0, e.is_cmd);
                    end
                end
                if (cmd_rdy && !rdy_q) begin
                    if (rxq.size() == 0) fail_unexp("cmd_rdy_unexpected");
                    else begin
                        e = rxq.pop_front();
                        chk("rx_kind_cmd", 1, e.is_cmd);
                        chk("cmd_value", cmd, e.val);
                        cur = e.val;
                    end
                end
                if (cmd_rdy) chk("cmd_stable", cmd, cur);
                rdy_q = cmd_rdy;
            end
        end
    end

    // Transmit status monitor: busy window, completion pulse, idle line
    initial begin
        bit in_win;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                in_win = (edge_cnt >= busy_start && edge_cnt < busy_start + 160) ||
                         (edge_cnt >= prev_start && edge_cnt < prev_start + 160);
                chk("tx_busy", tx_busy, in_win);
                chk("resp_sent", resp_sent,
                    (edge_cnt == busy_start + 160) || (edge_cnt == prev_start + 160));
                if (!in_win) chk("tx_idle_high", TX, 1);
            end
        end
    end

    // Transmit frame monitor: decodes the serial line at bit midpoints
    initial begin
        tx_ev_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && TX === 1'b0) begin
                if (txq.size() == 0) begin
                    fail_unexp("tx_unexpected_start");
                    for (int n = 0; n < 400 && TX !== 1'b1; n++) @(negedge clk);
                end else begin
                    e = txq.pop_front();
                    chk("tx_start_edge", edge_cnt, e.acc);
                    repeat (BAUD / 2) @(negedge clk);
                    chk("tx_start_bit", TX, 0);
                    for (int i = 0; i < 8; i++) begin
                        repeat (BAUD) @(negedge clk);
                        chk("tx_data_bit", TX, e.dat[i]);
                    end
                    repeat (BAUD) @(negedge clk);
                    chk("tx_stop_bit", TX, 1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        resp = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", TX, 1);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_resp_sent", resp_sent, 0);
        chk("rst_frm_err", frm_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // first command
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        chk("cmd1_rdy", cmd_rdy, 1);
        chk("cmd1_val", cmd, 24'h020001);

        // overrun while the command is unconsumed
        send_byte(8'h03, 1'b1);
        send_byte(8'h2E, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("overrun_rdy", cmd_rdy, 1);
        chk("overrun_cmd", cmd, 24'h020001);
        chk("overrun_events", rxq.size(), 0);
        clr_pulse();

        // bad stop bit restarts assembly
        send_byte(8'h77, 1'b1);
        send_byte(8'h13, 1'b0);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        chk("badstop_cmd", cmd, 24'h040134);
        clr_pulse();

        // response with a second request mid-frame
        send_tx(8'hA5);
        repeat (49) @(negedge clk);
        send_tx(8'h3C);
        repeat (130) @(negedge clk);

        // reset discards a partial command
        send_byte(8'h09, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        m_idx = 0;
        m_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_cmd", cmd, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (4) @(negedge clk);
        chk("postrst_cmd", cmd, 24'h050002);
        clr_pulse();

        // acknowledge held across completion: set must win for one cycle
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h33, 1'b1);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        chk("setwins_event_seen", rxq.size(), 0);
        chk("setwins_cleared", cmd_rdy, 0);

        // short glitch on the line
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        chk("glitch_no_event", rxq.size(), 0);

        // randomized full-duplex traffic
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    if (m_rdy && $urandom_range(0, 1) == 1) clr_pulse();
                    send_byte(8'($urandom), $urandom_range(0, 7) != 0);
                end
            end
            begin
                for (int n = 0; n < 10; n++) begin
                    repeat ($urandom_range(0, 220)) @(negedge clk);
                    send_tx(8'($urandom));
                end
            end
        join

        repeat (400) @(negedge clk);
        chk("rx_queue_drained", rxq.size(), 0);
        chk("tx_queue_drained", txq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_comm_slv.md
UART_COMM_SLV -- requirements
Module: uart_comm_slv

Interface
REQ-001 Parameter BAUD_DIV, default 4340, clk cycles per bit (115200 baud at 500 MHz); legal minimum 8.
REQ-002 clk  input  1  sole clock; all flops rise on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 RX  input  1  serial line from host; idle high; asynchronous to clk.
REQ-005 TX  output  1  serial line to host; idle high.
REQ-006 cmd  output  24  last assembled command; cmd[23:16] is the first byte received.
REQ-007 cmd_rdy  output  1  high while cmd holds an unconsumed command.
REQ-008 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-009 resp  input  8  response byte, sampled only when send_resp is accepted.
REQ-010 send_resp  input  1  request to transmit resp.
REQ-011 resp_sent  output  1  one-cycle pulse when a response frame completes.
REQ-012 tx_busy  output  1  high from send_resp acceptance until the end of the stop bit.
REQ-013 frm_err  output  1  one-cycle pulse on a bad stop bit or an overrun.

Function
REQ-014 RX SHALL pass through a two-flop synchronizer before any use; all receive logic uses only the synchronized value.
REQ-015 The receiver SHALL run as 8N1, LSB first, with states IDLE, START, DATA, STOP.
REQ-016 IDLE->START on a synchronized falling edge; bit samples taken at BAUD_DIV/2 into each bit period.
REQ-017 START->IDLE with no byte if RX is high at the start-bit midpoint (glitch rejection).
REQ-018 DATA shifts in 8 samples; STOP samples the stop bit; a low stop bit discards the byte, resets the byte index to 0 and pulses frm_err.
REQ-019 The receiver SHALL return to IDLE at the stop-bit midpoint so that back-to-back frames are accepted.
REQ-020 Valid bytes SHALL fill cmd[23:16], cmd[15:8], then cmd[7:0] in turn; a 2-bit byte index wraps 2->0.
REQ-021 Completing the third byte SHALL update cmd and set cmd_rdy on the same cycle.
REQ-022 cmd SHALL remain stable while cmd_rdy is high.
REQ-023 While cmd_rdy is high, each received valid byte SHALL be discarded and SHALL pulse frm_err (overrun); the index is not advanced.
REQ-024 clr_cmd_rdy SHALL clear cmd_rdy on the next cycle.
REQ-025 If clr_cmd_rdy coincides with a third byte completing, set wins: cmd_rdy stays high with the new cmd.
REQ-026 The transmitter SHALL use states IDLE, START, DATA, STOP and send a 10-bit frame (0, resp LSB first, 1), each bit BAUD_DIV cycles long.
REQ-027 send_resp SHALL be accepted only when tx_busy is low; it latches resp and starts the start bit on the next cycle.
REQ-028 send_resp while tx_busy is high SHALL be ignored.
REQ-029 resp_sent SHALL pulse on the cycle the stop bit ends, with tx_busy falling on that same cycle.
REQ-030 Receive and transmit SHALL operate independently and full-duplex.
REQ-031 The baud counter width SHALL be $clog2(BAUD_DIV); counters reload on every bit boundary with no accumulated drift.

Reset
REQ-032 rst SHALL force: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0, both FSMs to IDLE, byte index=0, synchronizer flops=1.
REQ-033 Reset mid-frame SHALL abandon any partial command and any partial response; no resp_sent follows.

Structure
REQ-034 A shared package uart_pkg SHALL hold the 4-state FSM enum, the frame constants (8 data bits, 1 stop bit) and the byte-index type.
REQ-035 A single sub-module uart_tx SHALL implement the transmitter; the receiver and command assembly live in uart_comm_slv.

Verification (BAUD_DIV=16)
REQ-036 Host sends 0x02,0x00,0x01 -> cmd=0x020001 and cmd_rdy high after the third stop-bit midpoint.
REQ-037 cmd_rdy high, host sends 0x03,0x2E,0x00 -> all three bytes discarded, frm_err pulses 3 times, cmd still 0x020001.
REQ-038 Byte 0x13 with stop bit forced low, then 0x04,0x01,0x34 -> one frm_err pulse, cmd=0x040134.
REQ-039 send_resp with resp=0xA5 -> TX carries 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit; resp_sent at cycle 160 after acceptance; a second send_resp at cycle 50 is ignored.
REQ-040 rst asserted after the 2nd byte, then 0x05,0x00,0x02 sent -> cmd=0x050002 with no stale bytes.
REQ-041 RX low pulse of 4 cycles -> no byte, no frm_err, FSM back in IDLE.
